// File: rtl/rv_hazard_ctrl.sv
// Hazard / flow-control unit for the 5-stage RV32 pipeline: shadow rd tracking, stalls, redirects, forwarding.
// Optional feature macro: RV_FWD_EN (EX forwarding, ID write-back bypass, single-cycle load-use stall).
module rv_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_s2,
  input  logic [REG_AW-1:0] rs2_s2,
  input  logic              rs1_used_s2,
  input  logic              rs2_used_s2,
  input  logic [REG_AW-1:0] rd_s2,
  input  logic              reg_write_s2,
  input  logic              mem_to_reg_s2,
  input  logic              redirect_s4,
  output logic              pc_en,
  output logic              en_s1_s2,
  output logic              clr_s1_s2,
  output logic              clr_s2_s3,
  output logic              clr_s3_s4,
  output logic [1:0]        fwd_a_s3,
  output logic [1:0]        fwd_b_s3,
  output logic              byp_rd1_s2,
  output logic              byp_rd2_s2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Shadow entries for EX(3), MEM(4), WB(5); valid already folds in wr && rd != 0.
  logic              v3, v4, v5;
  logic [REG_AW-1:0] rd3, rd4, rd5;
  logic              m1_3, m1_4, m1_5, m2_3, m2_4, m2_5;
  logic              hz, stall, wr_s2;

  assign m1_3  = rs1_used_s2 & v3 & (rs1_s2 == rd3);
  assign m1_4  = rs1_used_s2 & v4 & (rs1_s2 == rd4);
  assign m1_5  = rs1_used_s2 & v5 & (rs1_s2 == rd5);
  assign m2_3  = rs2_used_s2 & v3 & (rs2_s2 == rd3);
  assign m2_4  = rs2_used_s2 & v4 & (rs2_s2 == rd4);
  assign m2_5  = rs2_used_s2 & v5 & (rs2_s2 == rd5);
  assign wr_s2 = reg_write_s2 & (rd_s2 != '0);

`ifdef RV_FWD_EN
  logic       ld3;
  logic [1:0] fa_nx, fb_nx;

  assign hz    = (m1_3 | m2_3) & ld3;
  assign fa_nx = m1_3 ? 2'b01 : (m1_4 ? 2'b10 : 2'b00);
  assign fb_nx = m2_3 ? 2'b01 : (m2_4 ? 2'b10 : 2'b00);
  assign byp_rd1_s2 = m1_5;
  assign byp_rd2_s2 = m2_5;

  // Selects travel with the instruction into EX; a bubble or flush carries none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_s3 <= 2'b00;
      fwd_b_s3 <= 2'b00;
      ld3      <= 1'b0;
    end else if (stall | redirect_s4) begin
      fwd_a_s3 <= 2'b00;
      fwd_b_s3 <= 2'b00;
      ld3      <= 1'b0;
    end else begin
      fwd_a_s3 <= fa_nx;
      fwd_b_s3 <= fb_nx;
      ld3      <= mem_to_reg_s2;
    end
  end
`else
  logic unused_ld;

  // Without forwarding every pending producer blocks the consumer in ID.
  assign hz         = m1_3 | m1_4 | m1_5 | m2_3 | m2_4 | m2_5;
  assign fwd_a_s3   = 2'b00;
  assign fwd_b_s3   = 2'b00;
  assign byp_rd1_s2 = 1'b0;
  assign byp_rd2_s2 = 1'b0;
  assign unused_ld  = mem_to_reg_s2;
`endif

  // Redirect overrides any stall raised in the same cycle.
  assign stall     = hz & ~redirect_s4;
  assign pc_en     = ~stall;
  assign en_s1_s2  = ~stall;
  assign clr_s1_s2 = redirect_s4;
  assign clr_s2_s3 = redirect_s4 | stall;
  assign clr_s3_s4 = redirect_s4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; v4 <= 1'b0; v5 <= 1'b0;
      rd3 <= '0;  rd4 <= '0;  rd5 <= '0;
    end else begin
      v5  <= v4;
      rd5 <= rd4;
      if (redirect_s4) begin
        v4 <= 1'b0;
        v3 <= 1'b0;
      end else begin
        v4  <= v3;
        rd4 <= rd3;
        v3  <= stall ? 1'b0 : wr_s2;
        rd3 <= rd_s2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)      stall_cnt <= stall_cnt + 1'b1;
      if (redirect_s4) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: directed scenarios plus randomized traffic against an in-flight pipeline model.
module tb_rv_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1_s2, rs2_s2, rd_s2;
  logic          rs1_used_s2, rs2_used_s2, reg_write_s2, mem_to_reg_s2, redirect_s4;
  logic          pc_en, en_s1_s2, clr_s1_s2, clr_s2_s3, clr_s3_s4, byp_rd1_s2, byp_rd2_s2;
  logic [1:0]    fwd_a_s3, fwd_b_s3;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  rv_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_s2(rs1_s2), .rs2_s2(rs2_s2), .rs1_used_s2(rs1_used_s2), .rs2_used_s2(rs2_used_s2),
    .rd_s2(rd_s2), .reg_write_s2(reg_write_s2), .mem_to_reg_s2(mem_to_reg_s2),
    .redirect_s4(redirect_s4), .pc_en(pc_en), .en_s1_s2(en_s1_s2),
    .clr_s1_s2(clr_s1_s2), .clr_s2_s3(clr_s2_s3), .clr_s3_s4(clr_s3_s4),
    .fwd_a_s3(fwd_a_s3), .fwd_b_s3(fwd_b_s3), .byp_rd1_s2(byp_rd1_s2), .byp_rd2_s2(byp_rd2_s2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // In-flight instructions: slot 0 = EX, 1 = MEM, 2 = WB. A slot only holds real writers of a nonzero rd.
  bit        iv[3];
  int        ird[3];
  bit        ild[3];
  logic [1:0] m_fa, m_fb;
  logic [CW-1:0] m_scnt, m_fcnt;
  bit        e_stall, e_byp1, e_byp2;
  logic [1:0] nf_a, nf_b;

  function automatic int producer_age(input bit used, input int rs);
    if (used && rs != 0)
      for (int k = 0; k < 3; k++) if (iv[k] && ird[k] == rs) return k;
    return 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin iv[k] = 0; ird[k] = 0; ild[k] = 0; end
    m_fa = 0; m_fb = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_eval();
    int a1, a2;
    a1 = producer_age(rs1_used_s2, int'(rs1_s2));
    a2 = producer_age(rs2_used_s2, int'(rs2_s2));
`ifdef RV_FWD_EN
    e_stall = ((a1 == 0) || (a2 == 0)) && ild[0] && !redirect_s4;
    nf_a = (a1 == 0) ? 2'd1 : (a1 == 1) ? 2'd2 : 2'd0;
    nf_b = (a2 == 0) ? 2'd1 : (a2 == 1) ? 2'd2 : 2'd0;
    e_byp1 = rs1_used_s2 && iv[2] && ird[2] == int'(rs1_s2);
    e_byp2 = rs2_used_s2 && iv[2] && ird[2] == int'(rs2_s2);
`else
    e_stall = ((a1 < 3) || (a2 < 3)) && !redirect_s4;
    nf_a = 0; nf_b = 0; e_byp1 = 0; e_byp2 = 0;
`endif
  endtask

  task automatic model_commit();
    if (redirect_s4) begin
      iv[2] = iv[1]; ird[2] = ird[1]; ild[2] = ild[1];
      iv[1] = 0; iv[0] = 0;
      m_fa = 0; m_fb = 0; m_fcnt++;
    end else begin
      for (int k = 2; k > 0; k--) begin iv[k] = iv[k-1]; ird[k] = ird[k-1]; ild[k] = ild[k-1]; end
      if (e_stall) begin
        iv[0] = 0; m_fa = 0; m_fb = 0; m_scnt++;
      end else begin
        iv[0] = reg_write_s2 && rd_s2 != 0; ird[0] = int'(rd_s2); ild[0] = mem_to_reg_s2;
        m_fa = nf_a; m_fb = nf_b;
      end
    end
  endtask

  task automatic drive(input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit w, input bit ld, input bit rdr);
    rs1_s2 = AW'(r1); rs1_used_s2 = u1; rs2_s2 = AW'(r2); rs2_used_s2 = u2;
    rd_s2 = AW'(rd); reg_write_s2 = w; mem_to_reg_s2 = ld; redirect_s4 = rdr;
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds the instruction in ID until the model lets it advance, then clocks it into EX.
  task automatic issue(input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit w, input bit ld);
    for (int n = 0; n < 10; n++) begin
      drive(r1, u1, r2, u2, rd, w, ld, 0);
      #1 model_eval();
      if (!e_stall) break;
      if (n == 9) begin
        errors++;
        $display("FAIL issue_timeout: instruction still held after %0d cycles, required release", n + 1);
      end
      step();
    end
    step();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({pc_en, en_s1_s2, clr_s1_s2, clr_s2_s3, clr_s3_s4} !== 5'b11000) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 11000", {pc_en, en_s1_s2, clr_s1_s2, clr_s2_s3, clr_s3_s4});
    end
    checks++;
    if ({fwd_a_s3, fwd_b_s3, byp_rd1_s2, byp_rd2_s2} !== 6'b0) begin
      errors++; $display("FAIL reset_fwd: got %b, required 000000", {fwd_a_s3, fwd_b_s3, byp_rd1_s2, byp_rd2_s2});
    end
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_cnt: got stall=%0d flush=%0d, required 0 0", stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_fwd();
    logic [CW-1:0] base;
    nops(3);
    base = m_scnt;
    issue(2, 1, 3, 1, 1, 1, 0);
    issue(1, 1, 5, 1, 4, 1, 0);
    checks++;
`ifdef RV_FWD_EN
    if (fwd_a_s3 !== 2'b01 || stall_cnt !== base) begin
      errors++; $display("FAIL alu_fwd: got fwd_a=%b stall_cnt=%0d, required 01 %0d", fwd_a_s3, stall_cnt, base);
    end
`else
    if (fwd_a_s3 !== 2'b00 || stall_cnt !== base + 3) begin
      errors++; $display("FAIL alu_stall3: got fwd_a=%b stall_cnt=%0d, required 00 %0d", fwd_a_s3, stall_cnt, base + 3);
    end
`endif
  endtask

  task automatic test_load_use();
    logic [CW-1:0] base;
    nops(3);
    base = m_scnt;
    issue(2, 1, 0, 0, 1, 1, 1);
    drive(5, 1, 1, 1, 4, 1, 0, 0);
    #1;
    checks++;
    if (pc_en !== 1'b0 || clr_s2_s3 !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: got pc_en=%b clr_s2_s3=%b, required 0 1", pc_en, clr_s2_s3);
    end
    @(negedge clk);
    model_eval(); model_commit();
    issue(5, 1, 1, 1, 4, 1, 0);
    checks++;
`ifdef RV_FWD_EN
    if (fwd_b_s3 !== 2'b10 || stall_cnt !== base + 1) begin
      errors++; $display("FAIL load_use_fwd: got fwd_b=%b stall_cnt=%0d, required 10 %0d", fwd_b_s3, stall_cnt, base + 1);
    end
`else
    if (fwd_b_s3 !== 2'b00 || stall_cnt !== base + 3) begin
      errors++; $display("FAIL load_use_nofwd: got fwd_b=%b stall_cnt=%0d, required 00 %0d", fwd_b_s3, stall_cnt, base + 3);
    end
`endif
  endtask

  task automatic test_bypass();
    nops(3);
    issue(0, 1, 0, 0, 7, 1, 0);
    issue(2, 1, 3, 1, 8, 1, 0);
    issue(3, 1, 2, 1, 9, 1, 0);
    drive(7, 1, 0, 0, 10, 1, 0, 0);
    #1;
    checks++;
`ifdef RV_FWD_EN
    if (byp_rd1_s2 !== 1'b1 || pc_en !== 1'b1) begin
      errors++; $display("FAIL bypass: got byp_rd1=%b pc_en=%b, required 1 1", byp_rd1_s2, pc_en);
    end
`else
    if (byp_rd1_s2 !== 1'b0 || pc_en !== 1'b0) begin
      errors++; $display("FAIL bypass_nofwd: got byp_rd1=%b pc_en=%b, required 0 0", byp_rd1_s2, pc_en);
    end
`endif
    @(negedge clk);
    issue(7, 1, 0, 0, 10, 1, 0);
    checks++;
    if (fwd_a_s3 !== 2'b00) begin
      errors++; $display("FAIL bypass_fwd: got fwd_a=%b, required 00", fwd_a_s3);
    end
  endtask

  task automatic test_x0();
    logic [CW-1:0] base;
    nops(3);
    base = m_scnt;
    issue(1, 1, 2, 1, 0, 1, 1);
    issue(0, 1, 0, 1, 0, 1, 0);
    drive(0, 1, 0, 1, 3, 1, 0, 0);
    #1;
    checks++;
    if (pc_en !== 1'b1 || byp_rd1_s2 !== 1'b0 || byp_rd2_s2 !== 1'b0 || fwd_a_s3 !== 2'b00 || fwd_b_s3 !== 2'b00) begin
      errors++; $display("FAIL x0: got pc_en=%b byp=%b%b fwd=%b/%b, required 1 00 00/00",
                         pc_en, byp_rd1_s2, byp_rd2_s2, fwd_a_s3, fwd_b_s3);
    end
    @(negedge clk);
    issue(0, 1, 0, 1, 3, 1, 0);
    checks++;
    if (stall_cnt !== base || fwd_a_s3 !== 2'b00) begin
      errors++; $display("FAIL x0_cnt: got stall_cnt=%0d fwd_a=%b, required %0d 00", stall_cnt, fwd_a_s3, base);
    end
  endtask

  task automatic test_redirect_priority();
    logic [CW-1:0] sbase, fbase;
    nops(3);
    sbase = m_scnt; fbase = m_fcnt;
    issue(2, 1, 0, 0, 1, 1, 1);
    drive(1, 1, 1, 1, 4, 1, 0, 1);
    #1;
    model_eval();
    checks++;
    if ({clr_s1_s2, clr_s2_s3, clr_s3_s4, pc_en, en_s1_s2} !== 5'b11111) begin
      errors++; $display("FAIL redirect_ctrl: got %b, required 11111", {clr_s1_s2, clr_s2_s3, clr_s3_s4, pc_en, en_s1_s2});
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (flush_cnt !== fbase + 1 || stall_cnt !== sbase || clr_s1_s2 !== 1'b0) begin
      errors++; $display("FAIL redirect_cnt: got flush=%0d stall=%0d clr=%b, required %0d %0d 0",
                         flush_cnt, stall_cnt, clr_s1_s2, fbase + 1, sbase);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    nops(3);
    issue(2, 1, 0, 0, 1, 1, 1);
    drive(1, 1, 0, 0, 4, 1, 0, 0);
    #1;
    checks++;
    if (pc_en !== 1'b0) begin
      errors++; $display("FAIL mid_stall_pre: got pc_en=%b, required 0", pc_en);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pc_en !== 1'b1 || clr_s2_s3 !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL mid_stall_reset: got pc_en=%b clr_s2_s3=%b stall=%0d flush=%0d, required 1 0 0 0",
                         pc_en, clr_s2_s3, stall_cnt, flush_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [73:0] obs, exp;
    int r1, r2, rd;
    bit u1, u2, w, ld, rdr;
    bit held = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!held) begin
        r1 = $urandom_range(0, 4); r2 = $urandom_range(0, 4); rd = $urandom_range(0, 4);
        u1 = $urandom_range(0, 3) != 0; u2 = $urandom_range(0, 1);
        w = $urandom_range(0, 4) != 0; ld = $urandom_range(0, 2) == 0;
      end
      rdr = $urandom_range(0, 11) == 0;
      drive(r1, u1, r2, u2, rd, w, ld, rdr);
      #1 model_eval();
      obs = {pc_en, en_s1_s2, clr_s1_s2, clr_s2_s3, clr_s3_s4, byp_rd1_s2, byp_rd2_s2,
             fwd_a_s3, fwd_b_s3, stall_cnt, flush_cnt};
      exp = {!e_stall, !e_stall, rdr, rdr | e_stall, rdr, e_byp1, e_byp2, m_fa, m_fb, m_scnt, m_fcnt};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: got %h, required %h", c, obs, exp);
      end
      held = e_stall;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_bypass();
    test_x0();
    test_redirect_priority();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
